// File: rtl/video_cmd_sched.sv
// Sprite/font register-write scheduler: queues execute-stage writes and replays them
// to the video unit only inside blanking windows. Optional: VIDEO_CMD_COALESCE_EN.
module video_cmd_sched #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sp_we,
    input  logic [4:0]    sp_sel,
    input  logic [9:0]    sp_x,
    input  logic [8:0]    sp_y,
    input  logic [2:0]    sp_flags,
    input  logic          ft_we,
    input  logic [10:0]   ft_addr,
    input  logic [3:0]    ft_data,
    input  logic          vblank,
    input  logic          hblank,
    output logic          stall,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_is_font,
    output logic [4:0]    out_sp_sel,
    output logic [9:0]    out_x,
    output logic [8:0]    out_y,
    output logic [2:0]    out_flags,
    output logic [10:0]   out_ft_addr,
    output logic [3:0]    out_ft_data,
    output logic [AW:0]   sp_count,
    output logic [AW:0]   ft_count,
    output logic          late
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {RR_SPRITE = 1'b0, RR_FONT = 1'b1} rr_t;

    // Sprite entry {sel, x, y, flags}; font entry {addr, data}.
    logic [26:0]   sp_mem [DEPTH];
    logic [14:0]   ft_mem [DEPTH];

    logic [AW-1:0] sp_head_reg, sp_tail_reg, ft_head_reg, ft_tail_reg;
    logic [AW:0]   sp_count_reg, ft_count_reg;
    rr_t           rr_reg, rr_next;
    logic          vblank_reg, late_reg;

    logic          sp_full, ft_full, sp_elig, ft_elig, free;
    logic          grant_sp, grant_ft;
    logic          sp_push, ft_push, sp_coal;
    logic [AW-1:0] sp_wr_idx;
    logic [26:0]   sp_entry, sp_head_entry;
    logic [14:0]   ft_entry, ft_head_entry;

    assign sp_entry      = {sp_sel, sp_x, sp_y, sp_flags};
    assign ft_entry      = {ft_addr, ft_data};
    assign sp_head_entry = sp_mem[sp_head_reg];
    assign ft_head_entry = ft_mem[ft_head_reg];

    assign sp_full = (sp_count_reg == FULL);
    assign ft_full = (ft_count_reg == FULL);
    assign sp_elig = vblank & (sp_count_reg != '0);
    assign ft_elig = (vblank | hblank) & (ft_count_reg != '0);
    assign free    = ~out_valid | out_ready;

    always_comb begin
        grant_sp = 1'b0;
        grant_ft = 1'b0;
        rr_next  = rr_reg;
        if (free) begin
            if (sp_elig && (!ft_elig || rr_reg == RR_SPRITE)) begin
                grant_sp = 1'b1;
                rr_next  = RR_FONT;
            end else if (ft_elig) begin
                grant_ft = 1'b1;
                rr_next  = RR_SPRITE;
            end
        end
    end

`ifdef VIDEO_CMD_COALESCE_EN
    logic [AW-1:0] sp_last;
    logic [4:0]    sp_last_sel;
    assign sp_last     = sp_tail_reg - 1'b1;
    assign sp_last_sel = sp_mem[sp_last][26:22];
    // The newest entry is only being popped when it is also the head (single entry).
    assign sp_coal   = sp_we && (sp_count_reg != '0) && (sp_last_sel == sp_sel) &&
                       !(grant_sp && sp_count_reg == (AW+1)'(1));
    assign sp_wr_idx = sp_coal ? sp_last : sp_tail_reg;
`else
    assign sp_coal   = 1'b0;
    assign sp_wr_idx = sp_tail_reg;
`endif

    assign sp_push = sp_we & ~sp_full & ~sp_coal;
    assign ft_push = ft_we & ~ft_full;
    assign stall   = (sp_we & sp_full & ~sp_coal) | (ft_we & ft_full);

    always_ff @(posedge clk) begin
        if (sp_push || sp_coal)
            sp_mem[sp_wr_idx] <= sp_entry;
        if (ft_push)
            ft_mem[ft_tail_reg] <= ft_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_head_reg  <= '0;
            sp_tail_reg  <= '0;
            ft_head_reg  <= '0;
            ft_tail_reg  <= '0;
            sp_count_reg <= '0;
            ft_count_reg <= '0;
        end else begin
            if (sp_push) sp_tail_reg <= sp_tail_reg + 1'b1;
            if (grant_sp) sp_head_reg <= sp_head_reg + 1'b1;
            if (ft_push) ft_tail_reg <= ft_tail_reg + 1'b1;
            if (grant_ft) ft_head_reg <= ft_head_reg + 1'b1;
            sp_count_reg <= sp_count_reg + (AW+1)'(sp_push) - (AW+1)'(grant_sp);
            ft_count_reg <= ft_count_reg + (AW+1)'(ft_push) - (AW+1)'(grant_ft);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_reg <= RR_SPRITE;
        end else begin
            rr_reg <= rr_next;
        end
    end

    // Command register: only the launched kind's fields are reloaded; all hold under backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_is_font <= 1'b0;
            out_sp_sel  <= '0;
            out_x       <= '0;
            out_y       <= '0;
            out_flags   <= '0;
            out_ft_addr <= '0;
            out_ft_data <= '0;
        end else if (grant_sp) begin
            out_valid   <= 1'b1;
            out_is_font <= 1'b0;
            out_sp_sel  <= sp_head_entry[26:22];
            out_x       <= sp_head_entry[21:12];
            out_y       <= sp_head_entry[11:3];
            out_flags   <= sp_head_entry[2:0];
        end else if (grant_ft) begin
            out_valid   <= 1'b1;
            out_is_font <= 1'b1;
            out_ft_addr <= ft_head_entry[14:4];
            out_ft_data <= ft_head_entry[3:0];
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vblank_reg <= 1'b0;
            late_reg   <= 1'b0;
        end else begin
            vblank_reg <= vblank;
            if (vblank_reg && !vblank && sp_count_reg != '0)
                late_reg <= 1'b1;
        end
    end

    assign sp_count = sp_count_reg;
    assign ft_count = ft_count_reg;
    assign late     = late_reg;
endmodule
